spi_flash_icache: RTL and testbench
===================================

# spi_flash_icache

Direct-mapped, one-word-per-line read cache between the FemtoRV32 memory port and the memory-mapped SPI flash controller (program region 0x0000_0000–0x003F_FFFF). Hits return data the cycle after the read strobe with no busy stall. Misses forward a single read to the flash controller and fill the line. This removes the multi-ten-cycle SPI penalty from loop bodies executed out of flash.

## Interface
Parameters:
- LINES, 32: number of cache lines; power of two, 2..256.
- ADDR_W, 20: word-address width (byte address bits [21:2]).
- CNT_W, 16: width of the hit and miss performance counters.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; one clock, reset is asynchronous and active-low.
- word_address  in  ADDR_W  CPU word address, sampled when rstrb=1.
- rstrb  in  1  CPU read strobe; one-cycle pulse, already gated by the flash chip-select.
- rdata  out  32  registered read data to the CPU read mux.
- rbusy  out  1  stall to the CPU; ORed into mem_rbusy at top level.
- invalidate  in  1  one-cycle pulse; clears all valid bits.
- flash_word_address  out  ADDR_W  registered miss address to the flash controller.
- flash_rstrb  out  1  one-cycle read pulse to the flash controller.
- flash_rdata  in  32  flash controller read data.
- flash_rbusy  in  1  flash controller busy.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

## Operation
- IDX_W = log2(LINES). Index = word_address[IDX_W-1:0]. Tag = word_address[ADDR_W-1:IDX_W].
- Each line holds a valid bit, a tag and a 32-bit data word. Storage is in flops; lookup is combinational on the live word_address.
- FSM states:
  - IDLE
    - rstrb and hit: rdata <= line data; hit_count++; stay in IDLE.
    - rstrb and miss: latch address; flash_word_address <= word_address; rbusy <= 1; flash_rstrb <= 1; miss_count++; go to REQ.
  - REQ: one cycle; flash_rstrb <= 0; go to WAIT.
  - WAIT
    - flash_rbusy=1: hold.
    - flash_rbusy=0: line[idx] <= {valid=1, tag, flash_rdata}; rdata <= flash_rdata; rbusy <= 0; go to IDLE.
- rstrb outside IDLE is ignored; the CPU never strobes while rbusy=1.
- invalidate:
  - Clears all valid bits on the next edge.
  - Coinciding with an IDLE hit: the hit still returns data this access.
  - During REQ/WAIT: the fill still returns data to the CPU but does not set the line valid.
- Counters saturate at all-ones and do not wrap.
- Reset (async, any state):
  - FSM to IDLE; all valid bits 0; rdata=0, rbusy=0, flash_rstrb=0, flash_word_address=0, both counters 0.
  - Tags and data are not reset.
  - Reset mid-miss abandons the fill; the flash controller is reset by the same resetn.

## Timing
- All outputs are registered; there is no combinational path from an input to an output.
- Strobe at edge k, hit: rdata valid from cycle k+1; rbusy stays 0.
- Strobe at edge k, miss:
  - Cycle k+1: rbusy=1 and flash_rstrb=1.
  - flash_rbusy is assumed high from k+2 while the flash transfer runs. WAIT does not sample flash_rbusy before cycle k+2, so the controller's one-cycle registration delay is tolerated.
  - flash_rbusy first seen low at edge m (m ≥ k+2): rdata valid and rbusy=0 from cycle m+1.
  - Miss penalty = flash latency + 2 cycles.
- Back-to-back accesses:
  - A strobe in the cycle after a hit is legal.
  - A strobe at edge m+1 after a fill, to the same address, hits.

## Structure
- Package femto_cache_pkg holds:
  - the state enum (IDLE, REQ, WAIT);
  - a clog2-based IDX_W helper;
  - the line record typedef {valid, tag, data}.
- One sub-module: spi_flash_icache_store. It contains the line array with its combinational lookup (hit, data), the write port, and the bulk valid clear.
- FSM and counters live in the top of this block.

## Test plan
- Cold miss, then hit:
  - Stimulus: reset; read address 0x00010; flash model returns 0xDEADBEEF after 40 cycles.
  - Miss: rbusy high for 42 cycles; flash_rstrb pulses once with flash_word_address=0x00010.
  - Reading 0x00010 again returns 0xDEADBEEF in 1 cycle with rbusy=0.
  - Counters end at hit=1, miss=1.
- Conflict: read 0x00003, then 0x00023 (same index, LINES=32). Both miss. A re-read of 0x00003 misses again and returns the flash value.
- Invalidate:
  - Fill 4 lines, pulse invalidate, re-read all 4: all 4 miss.
  - Pulse invalidate during WAIT: the CPU gets the correct data and the next read of the same address misses.
- Reset mid-miss: assert resetn=0 during WAIT. All outputs are 0 immediately; after release, a read of the same address misses.
- Counter saturation: CNT_W=4, 20 hits. hit_count holds at 0xF.
- Sequential loop: 64 sequential addresses, then a second pass over all 64. Second pass is all hits for indices not aliased; with LINES=32 and 64 addresses, the second pass is all misses. Checked against a reference model.

Source files
------------

// File: rtl/femto_cache_pkg.sv
// Shared types and helpers for the SPI flash instruction cache.
package femto_cache_pkg;

  // Widest tag the line record can carry; narrower tags are zero-extended.
  localparam int TAG_W_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [31:0]          data;
  } line_t;

  // Index width for a power-of-two line count (at least one bit).
  function automatic int idx_w(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/spi_flash_icache_store.sv
// Line storage: valid/tag/data flops, combinational lookup, single write port
// and a bulk valid clear.
module spi_flash_icache_store
  import femto_cache_pkg::*;
#(
  parameter int LINES  = 32,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              hit,
  output logic [31:0]       hit_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_valid,
  input  logic [31:0]       wr_data,
  input  logic              inv
);

  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX_W-1:0] lk_idx, wr_idx;
  logic [TAG_W-1:0] lk_tag, wr_tag;
  line_t            cur_line;

  assign lk_idx = lk_addr[IDX_W-1:0];
  assign lk_tag = lk_addr[ADDR_W-1:IDX_W];
  assign wr_idx = wr_addr[IDX_W-1:0];
  assign wr_tag = wr_addr[ADDR_W-1:IDX_W];

  // Valid bits: reset and bulk clear win over a fill in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (inv) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
    end
  end

  // Tag and data are written on every fill and are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  // Combinational lookup on the live CPU address.
  always_comb begin
    cur_line.valid = valid_q[lk_idx];
    cur_line.tag   = TAG_W_MAX'(tag_q[lk_idx]);
    cur_line.data  = data_q[lk_idx];
    hit            = cur_line.valid && (cur_line.tag == TAG_W_MAX'(lk_tag));
    hit_data       = cur_line.data;
  end

endmodule

// File: rtl/spi_flash_icache.sv
// Direct-mapped one-word-per-line read cache in front of the SPI flash
// controller. Hits answer the cycle after the strobe; misses issue one flash
// read and fill the line.
module spi_flash_icache
  import femto_cache_pkg::*;
#(
  parameter int LINES  = 32,
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] word_address,
  input  logic              rstrb,
  output logic [31:0]       rdata,
  output logic              rbusy,
  input  logic              invalidate,
  output logic [ADDR_W-1:0] flash_word_address,
  output logic              flash_rstrb,
  input  logic [31:0]       flash_rdata,
  input  logic              flash_rbusy,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  state_t            state_q, state_d;
  logic [31:0]       rdata_d;
  logic              rbusy_d;
  logic              flash_rstrb_d;
  logic [ADDR_W-1:0] flash_addr_d;
  logic              poison_q, poison_d;
  logic              hit_inc, miss_inc;
  logic              fill_en, fill_valid;
  logic              hit;
  logic [31:0]       hit_data;

  spi_flash_icache_store #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk      (clk),
    .resetn   (resetn),
    .lk_addr  (word_address),
    .hit      (hit),
    .hit_data (hit_data),
    .wr_en    (fill_en),
    .wr_addr  (flash_word_address),
    .wr_valid (fill_valid),
    .wr_data  (flash_rdata),
    .inv      (invalidate)
  );

  // An invalidate seen while a miss is outstanding must keep that fill invalid.
  assign fill_valid = ~(poison_q | invalidate);

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q            <= IDLE;
      rdata              <= '0;
      rbusy              <= 1'b0;
      flash_rstrb        <= 1'b0;
      flash_word_address <= '0;
      poison_q           <= 1'b0;
    end else begin
      state_q            <= state_d;
      rdata              <= rdata_d;
      rbusy              <= rbusy_d;
      flash_rstrb        <= flash_rstrb_d;
      flash_word_address <= flash_addr_d;
      poison_q           <= poison_d;
    end
  end

  // Next-state and next-output decode; the flash address doubles as the
  // latched miss address used for the fill.
  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata;
    rbusy_d       = rbusy;
    flash_rstrb_d = 1'b0;
    flash_addr_d  = flash_word_address;
    poison_d      = poison_q | invalidate;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    fill_en       = 1'b0;
    case (state_q)
      IDLE: begin
        poison_d = 1'b0;
        if (rstrb) begin
          if (hit) begin
            rdata_d = hit_data;
            hit_inc = 1'b1;
          end else begin
            flash_addr_d  = word_address;
            rbusy_d       = 1'b1;
            flash_rstrb_d = 1'b1;
            miss_inc      = 1'b1;
            poison_d      = invalidate;
            state_d       = REQ;
          end
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!flash_rbusy) begin
          fill_en = 1'b1;
          rdata_d = flash_rdata;
          rbusy_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc && (hit_count != {CNT_W{1'b1}}))
        hit_count <= hit_count + CNT_W'(1);
      if (miss_inc && (miss_count != {CNT_W{1'b1}}))
        miss_count <= miss_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_spi_flash_icache.sv
// Bench for spi_flash_icache: constant vectors, sequential sweep and random
// accesses against a simple cache model, plus counter saturation on a
// narrow-counter instance.
module tb_spi_flash_icache;

  localparam int LINES  = 32;
  localparam int ADDR_W = 20;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [ADDR_W-1:0] word_address = '0;
  logic              rstrb = 1'b0;
  logic [31:0]       rdata;
  logic              rbusy;
  logic              invalidate = 1'b0;
  logic [ADDR_W-1:0] flash_word_address;
  logic              flash_rstrb;
  logic [31:0]       flash_rdata;
  logic              flash_rbusy;
  logic [CNT_W-1:0]  hit_count, miss_count;

  // Narrow-counter instance with an always-ready flash.
  logic [ADDR_W-1:0] s_addr = '0;
  logic              s_rstrb = 1'b0;
  logic [31:0]       s_rdata;
  logic              s_rbusy;
  logic [ADDR_W-1:0] s_faddr;
  logic              s_frstrb;
  logic [3:0]        s_hits, s_misses;

  always #5 clk = ~clk;

  spi_flash_icache #(.LINES(LINES), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .word_address       (word_address),
    .rstrb              (rstrb),
    .rdata              (rdata),
    .rbusy              (rbusy),
    .invalidate         (invalidate),
    .flash_word_address (flash_word_address),
    .flash_rstrb        (flash_rstrb),
    .flash_rdata        (flash_rdata),
    .flash_rbusy        (flash_rbusy),
    .hit_count          (hit_count),
    .miss_count         (miss_count)
  );

  spi_flash_icache #(.LINES(4), .ADDR_W(ADDR_W), .CNT_W(4)) dut_s (
    .clk                (clk),
    .resetn             (resetn),
    .word_address       (s_addr),
    .rstrb              (s_rstrb),
    .rdata              (s_rdata),
    .rbusy              (s_rbusy),
    .invalidate         (1'b0),
    .flash_word_address (s_faddr),
    .flash_rstrb        (s_frstrb),
    .flash_rdata        (32'h1234_5678),
    .flash_rbusy        (1'b0),
    .hit_count          (s_hits),
    .miss_count         (s_misses)
  );

  function automatic logic [31:0] flash_fn(input logic [ADDR_W-1:0] a);
    if (a == 20'h00010) return 32'hDEADBEEF;
    return {a[11:0], a} ^ 32'hA5C3_0F69;
  endfunction

  // Flash controller model: busy for cur_lat cycles after each strobe.
  int                cur_lat = 4;
  int                fcnt = 0;
  int                n_strobes = 0;
  logic [ADDR_W-1:0] fl_addr = '0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fcnt    <= 0;
      fl_addr <= '0;
    end else if (flash_rstrb) begin
      fcnt    <= cur_lat;
      fl_addr <= flash_word_address;
    end else if (fcnt != 0) begin
      fcnt <= fcnt - 1;
    end
  end

  always @(posedge clk) begin
    if (flash_rstrb) n_strobes <= n_strobes + 1;
  end

  assign flash_rbusy = (fcnt != 0);
  assign flash_rdata = flash_fn(fl_addr);

  // Cache reference model: per index, the full address held and its word.
  bit                mv [LINES];
  logic [ADDR_W-1:0] mt [LINES];
  logic [31:0]       md [LINES];
  int                m_hits = 0;
  int                m_misses = 0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < LINES; j++) mv[j] = 1'b0;
  endtask

  function automatic bit model_hit(input logic [ADDR_W-1:0] a);
    int idx;
    idx = int'(a) % LINES;
    return mv[idx] && (mt[idx] == a);
  endfunction

  // One CPU read; inv_at=0 pulses invalidate with the strobe, inv_at=n>0
  // pulses it during the n-th busy cycle, negative means no invalidate.
  task automatic do_read(input logic [ADDR_W-1:0] a, input int lat, input int inv_at,
                         output logic [31:0] d, output int busy, output int strb,
                         output logic [ADDR_W-1:0] fa);
    int s0;
    cur_lat = lat;
    s0 = n_strobes;
    @(negedge clk);
    word_address = a;
    rstrb = 1'b1;
    invalidate = (inv_at == 0);
    @(posedge clk); #1;
    rstrb = 1'b0;
    invalidate = 1'b0;
    busy = 0;
    while (rbusy === 1'b1 && busy < 2000) begin
      busy++;
      invalidate = (busy == inv_at);
      @(posedge clk); #1;
    end
    invalidate = 1'b0;
    d = rdata;
    strb = n_strobes - s0;
    fa = fl_addr;
  endtask

  task automatic run_access(input string nm, input logic [ADDR_W-1:0] a, input int lat,
                            input int inv_at, input bit use_tab, input int tb_busy,
                            input int tb_strb);
    logic [31:0]       ed, d;
    logic [ADDR_W-1:0] fa;
    bit                h;
    int                busy, strb, idx;
    idx = int'(a) % LINES;
    h = model_hit(a);
    ed = h ? md[idx] : flash_fn(a);
    do_read(a, lat, inv_at, d, busy, strb, fa);
    if (h) m_hits++;
    else   m_misses++;
    if (!h && inv_at < 0) begin
      mv[idx] = 1'b1;
      mt[idx] = a;
      md[idx] = ed;
    end
    if (inv_at >= 0) model_clear();
    check({nm, ".data"}, d, ed);
    if (use_tab) begin
      check({nm, ".busy"}, 32'(busy), 32'(tb_busy));
      check({nm, ".strobes"}, 32'(strb), 32'(tb_strb));
    end else begin
      check({nm, ".busy"}, 32'(busy), h ? 32'd0 : 32'(lat + 2));
      check({nm, ".strobes"}, 32'(strb), h ? 32'd0 : 32'd1);
    end
    if (!h) check({nm, ".flash_addr"}, 32'(fa), 32'(a));
    check({nm, ".hit_count"}, 32'(hit_count), 32'(m_hits));
    check({nm, ".miss_count"}, 32'(miss_count), 32'(m_misses));
  endtask

  task automatic pulse_inv();
    @(negedge clk);
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    model_clear();
  endtask

  typedef struct {
    bit                is_inv;
    logic [ADDR_W-1:0] addr;
    int                lat;
    int                inv_at;
    int                exp_busy;
    int                exp_strb;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic [ADDR_W-1:0] a;
    int                lat, inv;

    vecs[0]  = '{1'b0, 20'h00010, 40, -1, 42, 1};
    vecs[1]  = '{1'b0, 20'h00010, 40, -1, 0, 0};
    vecs[2]  = '{1'b0, 20'h00003, 5, -1, 7, 1};
    vecs[3]  = '{1'b0, 20'h00023, 5, -1, 7, 1};
    vecs[4]  = '{1'b0, 20'h00003, 5, -1, 7, 1};
    vecs[5]  = '{1'b0, 20'h00040, 3, -1, 5, 1};
    vecs[6]  = '{1'b0, 20'h00041, 3, -1, 5, 1};
    vecs[7]  = '{1'b0, 20'h00042, 3, -1, 5, 1};
    vecs[8]  = '{1'b0, 20'h00043, 3, -1, 5, 1};
    vecs[9]  = '{1'b1, 20'h00000, 0, -1, 0, 0};
    vecs[10] = '{1'b0, 20'h00040, 3, -1, 5, 1};
    vecs[11] = '{1'b0, 20'h00041, 3, -1, 5, 1};
    vecs[12] = '{1'b0, 20'h00042, 3, -1, 5, 1};
    vecs[13] = '{1'b0, 20'h00043, 3, -1, 5, 1};
    vecs[14] = '{1'b0, 20'h00055, 10, 4, 12, 1};
    vecs[15] = '{1'b0, 20'h00055, 10, -1, 12, 1};
    vecs[16] = '{1'b0, 20'h00055, 10, 0, 0, 0};
    vecs[17] = '{1'b0, 20'h00055, 10, -1, 12, 1};
    vecs[18] = '{1'b0, 20'h00056, 2, 1, 4, 1};
    vecs[19] = '{1'b0, 20'h00056, 2, -1, 4, 1};

    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset.rdata", rdata, 32'h0);
    check("reset.rbusy", 32'(rbusy), 32'h0);
    check("reset.flash_rstrb", 32'(flash_rstrb), 32'h0);
    check("reset.flash_addr", 32'(flash_word_address), 32'h0);
    check("reset.hit_count", 32'(hit_count), 32'h0);
    check("reset.miss_count", 32'(miss_count), 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].is_inv) pulse_inv();
      else run_access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].lat,
                      vecs[i].inv_at, 1'b1, vecs[i].exp_busy, vecs[i].exp_strb);
    end

    // Reset during a fill, then the same address must miss again.
    cur_lat = 30;
    @(negedge clk);
    word_address = 20'h00077;
    rstrb = 1'b1;
    @(posedge clk); #1;
    rstrb = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset.rdata", rdata, 32'h0);
    check("midreset.rbusy", 32'(rbusy), 32'h0);
    check("midreset.flash_rstrb", 32'(flash_rstrb), 32'h0);
    check("midreset.flash_addr", 32'(flash_word_address), 32'h0);
    check("midreset.hit_count", 32'(hit_count), 32'h0);
    check("midreset.miss_count", 32'(miss_count), 32'h0);
    model_clear();
    m_hits = 0;
    m_misses = 0;
    @(negedge clk);
    resetn = 1'b1;
    run_access("after_reset", 20'h00077, 3, -1, 1'b1, 5, 1);

    // Two passes over 64 sequential addresses; LINES=32 aliases them all.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 64; i++)
        run_access($sformatf("seq%0d_%0d", p, i), 20'h00100 + 20'(i),
                   int'($urandom_range(1, 4)), -1, 1'b0, 0, 0);

    // Random reads over a small pool with occasional invalidates.
    for (int n = 0; n < 150; n++) begin
      a = 20'h00200 + 20'($urandom_range(0, 39));
      lat = int'($urandom_range(1, 8));
      inv = -1;
      if ($urandom_range(0, 9) == 0)
        inv = model_hit(a) ? 0 : int'($urandom_range(1, lat + 2));
      run_access($sformatf("rnd%0d", n), a, lat, inv, 1'b0, 0, 0);
    end

    // Narrow counters: one fill, 20 back-to-back hits, then 20 conflict misses.
    @(negedge clk);
    s_addr = 20'h00005;
    s_rstrb = 1'b1;
    @(negedge clk);
    s_rstrb = 1'b0;
    repeat (3) @(negedge clk);
    check("sat.fill_data", s_rdata, 32'h1234_5678);
    s_rstrb = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("sat.hits14", 32'(s_hits), 32'd14);
    repeat (6) @(posedge clk);
    #1;
    s_rstrb = 1'b0;
    check("sat.hits20", 32'(s_hits), 32'hF);
    check("sat.rbusy", 32'(s_rbusy), 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_addr = 20'h00005 + 20'(4 * (i + 1));
      s_rstrb = 1'b1;
      @(negedge clk);
      s_rstrb = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("sat.misses", 32'(s_misses), 32'hF);
    check("sat.hits_hold", 32'(s_hits), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
